// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if -- request/result handshake bundle for the shift sequencer.
//   req_valid/req_ready : request handshake (requester -> sequencer)
//   req_signal          : 6-bit operation code (SLL/SRL/SRA)
//   req_data            : operand to shift
//   req_amount          : 32-bit shift amount, all bits significant
//   res_valid/res_ready : result handshake (sequencer -> consumer)
//   res_data/res_error  : result word and unsupported-code flag
// master = requester/consumer side, slave = sequencer side.
interface shift_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [5:0]       req_signal;
   logic [WIDTH-1:0] req_data;
   logic [31:0]      req_amount;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_error;

   modport master (
      output req_valid, req_signal, req_data, req_amount, res_ready,
      input  req_ready, res_valid, res_data, res_error
   );

   modport slave (
      input  req_valid, req_signal, req_data, req_amount, res_ready,
      output req_ready, res_valid, res_data, res_error
   );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer -- iterative shift unit controller. Takes one shift request
// at a time, shifts the operand by up to STEP positions per cycle and returns
// the result over a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : shift_sequencer_if.slave (request and result handshakes)
//   busy  : high while an operation is shifting or its result is pending
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_sequencer_if.slave      bus,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Operation kept as the low two code bits; only legal codes are latched.
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;
   localparam logic [4:0] STEP_K = 5'(STEP);

   state_t           state;
   logic [1:0]       op;
   logic [WIDTH-1:0] work;
   logic [4:0]       remaining;
   logic             rdy_q;
   logic             vld_q;
   logic             busy_q;
   logic             err_q;

   logic             supported;
   logic [4:0]       k;
   logic [WIDTH-1:0] shifted;

   assign supported = (bus.req_signal == 6'b000000) ||
                      (bus.req_signal == 6'b000010) ||
                      (bus.req_signal == 6'b000011);

   // Per-cycle step: a small mux over the constant shifts 1..STEP rather than
   // a full-width barrel shifter.
   always_comb begin
      k       = (remaining < STEP_K) ? remaining : STEP_K;
      shifted = work;
      for (int i = 1; i <= STEP; i++) begin
         if (k == 5'(i)) begin
            case (op)
               OP_SLL:  shifted = work << i;
               OP_SRL:  shifted = work >> i;
               default: shifted = WIDTH'($signed(work) >>> i);
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         op        <= OP_SLL;
         work      <= '0;
         remaining <= '0;
         rdy_q     <= 1'b1;
         vld_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op        <= bus.req_signal[1:0];
                  err_q     <= 1'b0;
                  remaining <= '0;
                  rdy_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  if (!supported) begin
                     work  <= '0;
                     err_q <= 1'b1;
                     vld_q <= 1'b1;
                     state <= DONE;
                  end else if (|bus.req_amount[31:5]) begin
                     // Everything shifted out: zeros, or sign fill for SRA.
                     work  <= (bus.req_signal[1:0] == OP_SRA) ?
                              {WIDTH{bus.req_data[WIDTH-1]}} : '0;
                     vld_q <= 1'b1;
                     state <= DONE;
                  end else if (bus.req_amount[4:0] == 5'd0) begin
                     work  <= bus.req_data;
                     vld_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     work      <= bus.req_data;
                     remaining <= bus.req_amount[4:0];
                     state     <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work      <= shifted;
               remaining <= remaining - k;
               if (remaining == k) begin
                  vld_q <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // Consuming edge only returns to IDLE; a pending request waits.
               if (bus.res_ready) begin
                  vld_q  <= 1'b0;
                  busy_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = rdy_q;
   assign bus.res_valid = vld_q;
   assign bus.res_data  = work;
   assign bus.res_error = err_q;
   assign busy          = busy_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit controller for the ALU datapath. Accepts one shift request at a time over a valid/ready handshake and performs it iteratively, at most STEP bit positions per cycle. Returns the result over a second valid/ready handshake. Sits beside the combinational ALU. The result feeds the same ALU/shifter output select, so shifts no longer need a single-cycle 32-bit barrel path.

## Interface
- WIDTH, 32: data width; must be 32 in this design (amount decode assumes 5-bit position).
- STEP, 4: maximum bit positions shifted per cycle; power of two, 1..16.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_signal  input  6  operation: SLL=6'b000000, SRL=6'b000010, SRA=6'b000011; all other codes unsupported.
- req_data  input  WIDTH  operand to shift (dataA).
- req_amount  input  32  shift amount (dataB), full 32 bits significant.
- res_valid  output  1  result present.
- res_ready  input  1  consumer takes result.
- res_data  output  WIDTH  shifted result.
- res_error  output  1  request carried an unsupported code; qualified by res_valid.
- busy  output  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE. All outputs come from registers or state decode only; no input-to-output combinational path.
- **IDLE:** req_ready=1.
  - On req_valid at a clock edge, latch op, data and amount. Next state is chosen by the first matching rule:
    - Unsupported code: res_data=0, res_error=1, go to DONE.
    - req_amount >= 32: res_data=0 for SLL/SRL; for SRA, all bits = req_data[31]. res_error=0, go to DONE.
    - req_amount == 0: res_data=req_data, go to DONE.
    - Otherwise: remaining = req_amount[4:0], go to SHIFT.
- **SHIFT:** each cycle, k = min(remaining, STEP).
  - Shift the working register by k: logical left for SLL, logical right for SRL, arithmetic right for SRA (sign taken from current bit 31).
  - remaining -= k. When remaining becomes 0, go to DONE with the result in res_data.
  - req_valid is ignored; req_ready=0.
- **DONE:** res_valid=1, with res_data and res_error stable.
  - On res_ready, go to IDLE.
  - No new request is accepted in the same edge the result is consumed; the next acceptance is the following edge at earliest.
- Unsupported codes must never enter SHIFT.

## Timing
- **Reset:** state=IDLE, req_ready=1, res_valid=0, res_data=0, res_error=0, busy=0, remaining=0.
  - reset has priority over every other input.
  - Asserted mid-SHIFT or in DONE, it aborts the operation and discards the result; res_valid is low in the cycle after the reset edge.
- **Latency:** request accepted at edge E. res_valid is high from edge E+1+ceil(amount/STEP) for 1 <= amount <= 31, and from edge E+1 for amount 0, amount >= 32 or unsupported codes.
- **Hold:** res_valid stays high, with res_data/res_error unchanged, until the edge where res_ready=1. It drops after that edge.
- **Throughput:** one request per (latency + 1) cycles minimum, since DONE to IDLE costs one edge.
- **Simultaneous events:** req_valid and res_ready both high in DONE: the result is consumed and the request is not accepted until IDLE.

## Test plan
- **SRL, STEP=4:** reset, then req SRL data=32'hF000_000F amount=5 -> req_ready drops, res_valid rises 3 edges after acceptance, res_data=32'h0780_0000, res_error=0.
- **SRA and SLL at boundaries:** SRA data=32'h8000_0000 amount=31 -> res_data=32'hFFFF_FFFF after 8 SHIFT cycles. SLL data=32'h0000_0001 amount=32 -> res_data=0 at E+1. SRA data=32'h8000_0001 amount=40 -> 32'hFFFF_FFFF at E+1.
- **Amount 0 and unsupported code:** amount 0 with data=32'h1234_5678 -> res_data=32'h1234_5678 at E+1. Signal=6'b100000 -> res_data=0, res_error=1 at E+1.
- **Backpressure:** hold res_ready=0 for 10 cycles with req_valid=1 throughout -> res_data stable, busy=1, req_ready=0, no second acceptance. Raise res_ready -> IDLE next edge, second request accepted the edge after.
- **Reset mid-operation:** SRL amount=31, assert reset on the 3rd SHIFT cycle -> next cycle state IDLE, res_valid=0, res_data=0, req_ready=1. A new request then completes correctly.
- **Random compare:** 10k random op/data/amount with random res_ready stalls -> every result matches a reference shift model (>> / << / >>> with the amount >= 32 rules above), and latency matches the formula.
